// File: rtl/systolic_feeder.sv
// systolic_feeder: skews input vectors into per-row delay chains for a systolic PE array.
// Row i sees element i after i+1 advances; a block end triggers N-1 zero-fill flush advances.
module systolic_feeder #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] s_data,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  input  logic               m_ready,
  output logic [N*WIDTH-1:0] a_out,
  output logic               a_valid,
  output logic               done,
  output logic [15:0]        vec_cnt
);
  localparam int FW = (N > 2) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;
  state_t state_q, state_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [15:0] vec_cnt_q, vec_cnt_d;
  logic a_valid_q, a_valid_d, done_q, done_d;
  logic accept, flush_adv, advance, last_flush;
  assign s_ready    = m_ready && (state_q != FLUSH);
  assign accept     = s_valid && s_ready;
  assign flush_adv  = (state_q == FLUSH) && m_ready;
  assign advance    = accept || flush_adv;
  assign last_flush = flush_adv && (fcnt_q == FW'(N-2));
  always_comb begin
    state_d   = accept ? (s_last ? FLUSH : STREAM) : last_flush ? IDLE : state_q;
    fcnt_d    = last_flush ? '0 : flush_adv ? fcnt_q + FW'(1) : fcnt_q;
    vec_cnt_d = !accept ? vec_cnt_q : (state_q == IDLE) ? 16'd1 :
                (vec_cnt_q == 16'hFFFF) ? vec_cnt_q : vec_cnt_q + 16'd1;
    a_valid_d = advance;
    done_d    = last_flush;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      fcnt_q    <= '0;
      vec_cnt_q <= '0;
      a_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      vec_cnt_q <= vec_cnt_d;
      a_valid_q <= a_valid_d;
      done_q    <= done_d;
    end
  end
  assign a_valid = a_valid_q;
  assign done    = done_q;
  assign vec_cnt = vec_cnt_q;
  // Row i is a chain of i+1 registers; flush advances shift zeros in behind the data.
  for (genvar i = 0; i < N; i++) begin : g_row
    logic [WIDTH-1:0] row_q [i+1];
    logic [WIDTH-1:0] row_d [i+1];
    logic [WIDTH-1:0] head;
    assign head = accept ? s_data[i*WIDTH +: WIDTH] : '0;
    always_comb begin
      row_d[0] = advance ? head : row_q[0];
      for (int j = 1; j <= i; j++) row_d[j] = advance ? row_q[j-1] : row_q[j];
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j <= i; j++) row_q[j] <= '0;
      end else begin
        row_q <= row_d;
      end
    end
    assign a_out[i*WIDTH +: WIDTH] = row_q[i];
  end
endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter WIDTH, default 8: signed element width in bits.
REQ-002 Parameter N, default 4: number of array rows and elements per input vector (N >= 2).
REQ-003 clk  input  1: single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1: reset, asynchronous and active-low.
REQ-005 s_data  input  N*WIDTH: input vector; element i occupies bits [i*WIDTH +: WIDTH], signed.
REQ-006 s_valid  input  1: s_data and s_last are valid.
REQ-007 s_last  input  1: current vector is the last of a block.
REQ-008 s_ready  output  1: feeder accepts a vector this cycle.
REQ-009 m_ready  input  1: the PE array may advance this cycle.
REQ-010 a_out  output  N*WIDTH: skewed row operands; row i occupies bits [i*WIDTH +: WIDTH], drives row i a_in.
REQ-011 a_valid  output  1: a_out holds a freshly advanced skew column.
REQ-012 done  output  1: one-cycle pulse when a block has fully drained.
REQ-013 vec_cnt  output  16: number of vectors accepted in the current block.

Function
REQ-014 States: IDLE, STREAM, FLUSH. No other states are reachable.
REQ-015 s_ready = m_ready AND (state is IDLE or STREAM), combinational.
REQ-016 accept = s_valid AND s_ready; advance = accept OR (state is FLUSH AND m_ready).
REQ-017 Row i is a register chain of depth i+1; all chains shift only on advance and hold otherwise.
REQ-018 On accept, element i of s_data enters the head of chain i. On a FLUSH advance, zero enters every chain head.
REQ-019 Row i output equals the tail of chain i, so element i of an accepted vector appears on a_out row i after i+1 advances, counting the accepting advance.
REQ-020 a_valid is registered: a_valid <= advance.
REQ-021 IDLE -> STREAM on accept with s_last = 0. IDLE -> FLUSH on accept with s_last = 1. STREAM -> FLUSH on accept with s_last = 1.
REQ-022 STREAM holds on s_valid = 0 or m_ready = 0. Stall cycles insert no bubbles and no zeros.
REQ-023 FLUSH performs exactly N-1 advances. A flush counter counts 0..N-2, increments only on a FLUSH advance, and is not advanced while m_ready = 0.
REQ-024 On the (N-1)th FLUSH advance, the block returns to IDLE and done is asserted on the next cycle for exactly one cycle.
REQ-025 After done, the final vector's element N-1 has reached row N-1, and all chains contain only that vector's tail plus zeros.
REQ-026 vec_cnt increments by 1 on each accept and saturates at 16'hFFFF.
REQ-027 On an accept taken in IDLE, vec_cnt loads 1, so a new block restarts the count.
REQ-028 s_data is ignored when not accepted. s_last is sampled only on accept.
REQ-029 Data passes through unmodified, with no arithmetic or sign change.

Reset
REQ-030 While rst_n = 0: state = IDLE, all chain registers = 0, a_out = 0, a_valid = 0, done = 0, vec_cnt = 0, flush counter = 0.
REQ-031 s_ready follows REQ-015 during reset and after reset (IDLE).
REQ-032 A reset asserted mid-STREAM or mid-FLUSH abandons the block, with no done pulse.
REQ-033 After rst_n deasserts, the first accept starts a fresh block.

Verification
REQ-034 N=4, m_ready=1; vectors {1,2,3,4}, {5,6,7,8} with s_last on the second -> rows 0..3 at advances 1..5:
- row0 = 1, 5, 0, 0, 0
- row3 = 0, 0, 0, 4, 8
- done pulses once after the 3rd FLUSH advance
- vec_cnt = 2
REQ-035 Single vector {-1,-2,-3,-4} (8'hFF, 8'hFE, 8'hFD, 8'hFC) with s_last -> IDLE goes directly to FLUSH; row3 shows 8'hFC on advance 4; a_valid is high for exactly 4 cycles.
REQ-036 m_ready=0 for 3 cycles in the middle of STREAM and then in the middle of FLUSH -> a_out held, a_valid=0, s_ready=0 during the stall; skew sequence identical to the no-stall run; flush still takes exactly 3 advances.
REQ-037 s_valid toggling 1-0-1 in STREAM -> no zero inserted between vectors; row0 shows consecutive elements on consecutive a_valid cycles.
REQ-038 rst_n low for 1 cycle during the 2nd FLUSH advance -> all outputs 0 immediately, no done pulse; a subsequent block gives vec_cnt = 1 on its first accept.
REQ-039 Back-to-back blocks with s_valid held high -> s_ready=0 for 3 FLUSH cycles; the new block is accepted in IDLE the cycle after FLUSH exits; done and the first new accept do not corrupt vec_cnt.
